rng_harvest: RTL

Consumer side of the on-chip random source. Samples the cellular-automaton state word every cycle, folds it to one raw bit, optionally von-Neumann debiases it, packs accepted bits into OUT_W-bit words and buffers them in a small FIFO. Words are handed to the crypto datapath over a valid/ready port. A repetition-count health test gates the output and latches an alarm on a stuck source.

---
 rtl/rng_harvest.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/rng_harvest.sv
// rng_harvest: folds CA state to raw bits, packs words, FIFOs them, health-gates output.
// Optional RNG_VN_DEBIAS_EN enables von Neumann debiasing of the raw bit stream.
module rng_harvest #(
  parameter int WIDTH      = 32,
  parameter int OUT_W      = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int REP_LIMIT  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [WIDTH-1:0]              raw_i,
  output logic [OUT_W-1:0]              rnd_o,
  output logic                          rnd_valid_o,
  input  logic                          rnd_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          alarm_o,
  input  logic                          clr_alarm_i
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(OUT_W + 1);
  localparam int RW = 8;

  typedef enum logic [1:0] {
    IDLE,
    HARVEST,
    STALL,
    ALARM
  } state_t;

  state_t state, state_nx;

  logic [OUT_W-1:0] stage, stage_nx;
  logic [OUT_W-1:0] stage_ins;
  logic [OUT_W-1:0] push_word;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [RW-1:0]    rep, rep_nx, rep_run;
  logic             last_rb, last_nx;
  logic             rb;
  logic             bit_ok, bit_val;
  logic             done, trip;
  logic             push, pop, flush;
  logic             full, empty, can_push;

  logic [OUT_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic [AW:0]      level;

`ifdef RNG_VN_DEBIAS_EN
  logic half_v, half_v_nx;
  logic half_b, half_b_nx;
`endif

  assign rb = ^raw_i;

  assign rep_run = (rep != '0 && rb == last_rb) ? rep + 1'b1 : RW'(1);
  assign trip    = en && (rep_run == RW'(REP_LIMIT));

`ifdef RNG_VN_DEBIAS_EN
  // second half of a pair: differing halves yield the first half
  assign bit_ok  = en && half_v && (half_b != rb);
  assign bit_val = half_b;
`else
  assign bit_ok  = en;
  assign bit_val = rb;
`endif

  assign stage_ins = stage | (OUT_W'(bit_val) << cnt);
  assign done      = cnt == CW'(OUT_W - 1);

  assign full     = level == (AW + 1)'(FIFO_DEPTH);
  assign empty    = level == '0;
  assign pop      = rnd_valid_o && rnd_ready_i;
  assign can_push = !full || pop;

  assign rnd_valid_o  = !empty && (state != ALARM);
  assign rnd_o        = empty ? '0 : mem[rd_ptr];
  assign fifo_level_o = level;
  assign alarm_o      = state == ALARM;

  always_comb begin
    state_nx  = state;
    stage_nx  = stage;
    cnt_nx    = cnt;
    rep_nx    = rep;
    last_nx   = last_rb;
    push      = 1'b0;
    push_word = stage;
    flush     = 1'b0;
`ifdef RNG_VN_DEBIAS_EN
    half_v_nx = half_v;
    half_b_nx = half_b;
`endif
    unique case (state)
      IDLE: begin
        stage_nx = '0;
        cnt_nx   = '0;
        rep_nx   = '0;
`ifdef RNG_VN_DEBIAS_EN
        half_v_nx = 1'b0;
`endif
        if (en) state_nx = HARVEST;
      end
      HARVEST: begin
        if (!en || trip) begin
          state_nx = en ? ALARM : IDLE;
          flush    = en;
          stage_nx = '0;
          cnt_nx   = '0;
          rep_nx   = '0;
`ifdef RNG_VN_DEBIAS_EN
          half_v_nx = 1'b0;
`endif
        end else begin
          rep_nx  = rep_run;
          last_nx = rb;
`ifdef RNG_VN_DEBIAS_EN
          half_v_nx = !half_v;
          half_b_nx = rb;
`endif
          if (bit_ok) begin
            if (!done) begin
              stage_nx = stage_ins;
              cnt_nx   = cnt + 1'b1;
            end else if (can_push) begin
              push      = 1'b1;
              push_word = stage_ins;
              stage_nx  = '0;
              cnt_nx    = '0;
            end else begin
              state_nx = STALL;
              stage_nx = stage_ins;
              cnt_nx   = CW'(OUT_W);
            end
          end
        end
      end
      STALL: begin
        rep_nx = '0;
`ifdef RNG_VN_DEBIAS_EN
        half_v_nx = 1'b0;
`endif
        if (can_push) begin
          push     = 1'b1;
          stage_nx = '0;
          cnt_nx   = '0;
          state_nx = en ? HARVEST : IDLE;
        end else if (!en) begin
          stage_nx = '0;
          cnt_nx   = '0;
          state_nx = IDLE;
        end
      end
      ALARM: begin
        flush    = 1'b1;
        stage_nx = '0;
        cnt_nx   = '0;
        rep_nx   = '0;
`ifdef RNG_VN_DEBIAS_EN
        half_v_nx = 1'b0;
`endif
        if (clr_alarm_i) state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      stage   <= '0;
      cnt     <= '0;
      rep     <= '0;
      last_rb <= 1'b0;
`ifdef RNG_VN_DEBIAS_EN
      half_v  <= 1'b0;
      half_b  <= 1'b0;
`endif
    end else begin
      state   <= state_nx;
      stage   <= stage_nx;
      cnt     <= cnt_nx;
      rep     <= rep_nx;
      last_rb <= last_nx;
`ifdef RNG_VN_DEBIAS_EN
      half_v  <= half_v_nx;
      half_b  <= half_b_nx;
`endif
    end
  end

  // flush wins over any push/pop in the same cycle
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + (AW + 1)'(push) - (AW + 1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_word;
  end

endmodule
